flash_sample_reader: RTL and testbench
======================================

Name: flash_sample_reader

Overview:
- Sits between the flash address counter and the audio output path.
- Issues one Avalon-MM read per flash address and captures the 32-bit word.
- Emits the word as two 16-bit samples, one per sample_tick.
- Pulses addr_change so the address counter steps to the next word. Half order follows play direction.

Parameters:
ADDR_WIDTH, 23, width of the flash word address
DATA_WIDTH, 32, flash read data width; must equal 2*SAMPLE_WIDTH
SAMPLE_WIDTH, 16, output sample width

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
enable  in  1  playback enable (1 = run, 0 = pause)
forward  in  1  play direction (1 = forward, 0 = reverse); same signal drives the address counter
sample_tick  in  1  one-cycle sample-rate strobe
address  in  ADDR_WIDTH  current word address from the address counter
addr_change  out  1  one-cycle pulse; steps the address counter
flash_read  out  1  Avalon read request
flash_address  out  ADDR_WIDTH  Avalon address, latched
flash_waitrequest  in  1  Avalon stall
flash_readdata  in  DATA_WIDTH  Avalon read data
flash_readdatavalid  in  1  Avalon data qualifier
sample_out  out  SAMPLE_WIDTH  current sample; held between updates
sample_valid  out  1  one-cycle pulse when sample_out updates

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All outputs 0: flash_read, flash_address, addr_change, sample_out, sample_valid. Word and direction registers 0. Any in-flight read is abandoned.
- All outputs are registered.
- IDLE: if enable=1, go to REQ.
- REQ:
  - On entry, latch flash_address<=address and dir<=forward, and set flash_read=1.
  - Hold flash_read and flash_address stable while flash_waitrequest=1.
  - On the first edge with flash_waitrequest=0, drop flash_read and go to WAIT_DATA.
- WAIT_DATA: on flash_readdatavalid=1, latch word<=flash_readdata and go to FIRST.
  - REQ and WAIT_DATA always run to completion; enable is ignored there.
- FIRST: on sample_tick=1 with enable=1:
  - sample_out<=word[15:0] if dir=1, else word[31:16].
  - sample_valid=1 on the next cycle.
  - Go to SECOND.
- SECOND: on sample_tick=1 with enable=1:
  - Output the other half.
  - sample_valid=1.
  - Go to ADVANCE.
- ADVANCE: addr_change=1 for exactly one cycle, then go to SETTLE.
- SETTLE: one idle cycle so the updated address is stable. Then go to REQ if enable=1, else IDLE.
- Latency: sample_tick edge to sample_valid/sample_out is exactly 1 cycle.
- Exactly one addr_change per two sample_valid pulses. Never more than one outstanding read.
- sample_tick outside FIRST/SECOND (or with enable=0) is dropped. It does not queue.
- enable=0 in FIRST/SECOND: state is held and the word is preserved. Resume continues from the same half.
- sample_tick coincident with flash_readdatavalid in WAIT_DATA: the tick is dropped. The word is still captured.
- forward changed mid-word: ignored until the next REQ (dir latched in REQ).
- Address wrap-around is owned by the address counter. This block passes address through unmodified.

Optional Feature:
SAMPLE_UNDERRUN_EN:
- Defined: adds output underrun_count, 16 bits, reset 0.
- It increments by 1 on every sample_tick with enable=1 while the state is not FIRST or SECOND, and saturates at 0xFFFF.
- Undefined: the port and counter are absent, and dropped ticks are silent.

Test Plan:
- Reset then enable=1, forward=1, address=0x000010, waitrequest 0, readdatavalid 2 cycles after read, readdata=0xBEEF1234, two ticks -> flash_address=0x000010; sample_out 0x1234 then 0xBEEF, each with a 1-cycle sample_valid one cycle after its tick; one addr_change pulse after the second sample.
- forward=0, same word -> sample_out 0xBEEF then 0x1234; one addr_change.
- flash_waitrequest held 1 for 5 cycles -> flash_read and flash_address stable all 5 cycles; flash_read drops the cycle after waitrequest=0; no second read issued.
- enable dropped after the first sample for 20 cycles with 3 ticks -> no sample_valid, no addr_change; on re-enable the next tick yields the second half (0xBEEF), then addr_change.
- rst=0 asserted in WAIT_DATA -> outputs 0 immediately without a clock edge; after release with enable=1, REQ re-issues using the current address.
- SAMPLE_UNDERRUN_EN defined, tick coincident with readdatavalid, plus 2 ticks during REQ -> underrun_count=3; preset near 0xFFFF then force further underruns -> count holds at 0xFFFF.

Source files
------------

// File: rtl/flash_sample_reader_if.sv
// Avalon-MM read-only bus between flash_sample_reader and the flash.
// master drives the request, slave answers with stall and read data.
interface flash_sample_reader_if #(
  parameter int ADDR_WIDTH = 23,
  parameter int DATA_WIDTH = 32
);
  logic                  flash_read;
  logic [ADDR_WIDTH-1:0] flash_address;
  logic                  flash_waitrequest;
  logic [DATA_WIDTH-1:0] flash_readdata;
  logic                  flash_readdatavalid;

  modport master (
    output flash_read,
    output flash_address,
    input  flash_waitrequest,
    input  flash_readdata,
    input  flash_readdatavalid
  );

  modport slave (
    input  flash_read,
    input  flash_address,
    output flash_waitrequest,
    output flash_readdata,
    output flash_readdatavalid
  );
endinterface

// File: rtl/flash_sample_reader.sv
// Reads one flash word per address and plays it out as two samples.
// Optional SAMPLE_UNDERRUN_EN adds a saturating dropped-tick counter.
module flash_sample_reader #(
  parameter int ADDR_WIDTH   = 23,
  parameter int DATA_WIDTH   = 32,
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    forward,
  input  logic                    sample_tick,
  input  logic [ADDR_WIDTH-1:0]   address,
  output logic                    addr_change,
  flash_sample_reader_if.master   flash,
  output logic [SAMPLE_WIDTH-1:0] sample_out,
  output logic                    sample_valid
`ifdef SAMPLE_UNDERRUN_EN
  ,
  output logic [15:0]             underrun_count
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_DATA,
    FIRST,
    SECOND,
    ADVANCE,
    SETTLE
  } state_e;

  state_e                  state_q, state_d;
  logic                    flash_read_q, flash_read_d;
  logic [ADDR_WIDTH-1:0]   flash_address_q, flash_address_d;
  logic                    dir_q, dir_d;
  logic [DATA_WIDTH-1:0]   word_q, word_d;
  logic [SAMPLE_WIDTH-1:0] sample_q, sample_d;
  logic                    sample_valid_q, sample_valid_d;
  logic                    addr_change_q, addr_change_d;

  logic                    tick_ok;
  logic                    enter_req;
  logic [SAMPLE_WIDTH-1:0] lo_half, hi_half;

  assign tick_ok = sample_tick & enable;
  assign lo_half = word_q[SAMPLE_WIDTH-1:0];
  assign hi_half = word_q[DATA_WIDTH-1 -: SAMPLE_WIDTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      flash_read_q    <= 1'b0;
      flash_address_q <= '0;
      dir_q           <= 1'b0;
      word_q          <= '0;
      sample_q        <= '0;
      sample_valid_q  <= 1'b0;
      addr_change_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      flash_read_q    <= flash_read_d;
      flash_address_q <= flash_address_d;
      dir_q           <= dir_d;
      word_q          <= word_d;
      sample_q        <= sample_d;
      sample_valid_q  <= sample_valid_d;
      addr_change_q   <= addr_change_d;
    end
  end

  // REQ and WAIT_DATA ignore enable so a read is never abandoned mid-way.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (enable) state_d = REQ;
      REQ:       if (!flash.flash_waitrequest) state_d = WAIT_DATA;
      WAIT_DATA: if (flash.flash_readdatavalid) state_d = FIRST;
      FIRST:     if (tick_ok) state_d = SECOND;
      SECOND:    if (tick_ok) state_d = ADVANCE;
      ADVANCE:   state_d = SETTLE;
      SETTLE:    state_d = enable ? REQ : IDLE;
      default:   state_d = IDLE;
    endcase
  end

  assign enter_req = (state_d == REQ) && (state_q != REQ);

  always_comb begin
    flash_read_d    = flash_read_q;
    flash_address_d = flash_address_q;
    dir_d           = dir_q;
    word_d          = word_q;
    sample_d        = sample_q;
    sample_valid_d  = 1'b0;
    addr_change_d   = (state_d == ADVANCE);
    unique case (1'b1)
      enter_req: begin
        flash_read_d    = 1'b1;
        flash_address_d = address;
        dir_d           = forward;
      end
      (state_q == REQ) && !flash.flash_waitrequest:
        flash_read_d = 1'b0;
      (state_q == WAIT_DATA) && flash.flash_readdatavalid:
        word_d = flash.flash_readdata;
      (state_q == FIRST) && tick_ok: begin
        sample_d       = dir_q ? lo_half : hi_half;
        sample_valid_d = 1'b1;
      end
      (state_q == SECOND) && tick_ok: begin
        sample_d       = dir_q ? hi_half : lo_half;
        sample_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign flash.flash_read    = flash_read_q;
  assign flash.flash_address = flash_address_q;
  assign addr_change         = addr_change_q;
  assign sample_out          = sample_q;
  assign sample_valid        = sample_valid_q;

`ifdef SAMPLE_UNDERRUN_EN
  logic [15:0] underrun_q, underrun_d;
  logic        playing;

  assign playing = (state_q == FIRST) || (state_q == SECOND);

  always_comb begin
    underrun_d = underrun_q;
    if (tick_ok && !playing && (underrun_q != 16'hFFFF))
      underrun_d = underrun_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) underrun_q <= '0;
    else      underrun_q <= underrun_d;
  end

  assign underrun_count = underrun_q;
`endif

endmodule

// File: tb/tb_flash_sample_reader.sv
// Bench for flash_sample_reader: directed table, corner sequences and
// randomized playback against a sample-stream reference model.
module tb_flash_sample_reader;
  localparam int AW = 23;
  localparam int DW = 32;
  localparam int SW = 16;

  logic          clk = 0;
  logic          rst = 0;
  logic          enable = 0;
  logic          forward = 1;
  logic          sample_tick = 0;
  logic [AW-1:0] address = '0;
  logic          addr_change;
  logic [SW-1:0] sample_out;
  logic          sample_valid;
`ifdef SAMPLE_UNDERRUN_EN
  logic [15:0]   underrun_count;
`endif

  flash_sample_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) fif ();

  flash_sample_reader #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SAMPLE_WIDTH(SW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .forward(forward),
    .sample_tick(sample_tick),
    .address(address),
    .addr_change(addr_change),
    .flash(fif),
    .sample_out(sample_out),
    .sample_valid(sample_valid)
`ifdef SAMPLE_UNDERRUN_EN
    ,
    .underrun_count(underrun_count)
`endif
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    ncmp++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] mem(logic [AW-1:0] a);
    return {a[15:0] ^ 16'hC35A, a[22:7] + 16'h1F0D};
  endfunction

  // First half in play order is the low half when forward.
  function automatic logic [15:0] half(logic [31:0] w, bit fwd, int idx);
    return ((idx == 0) == fwd) ? w[15:0] : w[31:16];
  endfunction

  // Flash slave configuration and state
  int            wr_hold_cfg = 0;
  int            wr_pct = 0;
  int            lat_cfg = 2;
  bit            rand_lat = 0;
  bit            use_ovr = 1;
  logic [31:0]   ovr_data = '0;
  bit            pend = 0;
  int            cnt = 0;
  int            rd_done = 0;
  logic [AW-1:0] acc_addr = '0;
  logic [AW-1:0] pend_addr = '0;
  bit            in_req = 0;
  int            hold_left = 0;
  bit            stalled = 0;
  logic [AW-1:0] stall_addr = '0;
  int            stall_cur = 0;
  int            stall_last = 0;

  // Reference model state
  bit            mon_en = 0;
  logic [AW-1:0] model_addr = '0;
  int            model_half = 0;
  bit            prev_te = 0;
  int            pair_cnt = 0;
  int            sv_total = 0;
  int            ac_total = 0;

  initial begin
    fif.flash_waitrequest   = 0;
    fif.flash_readdata      = '0;
    fif.flash_readdatavalid = 0;
  end

  task automatic responder_step();
    bit wr;
    fif.flash_readdatavalid = 0;
    if (!rst) begin
      pend = 0;
      in_req = 0;
      stalled = 0;
      fif.flash_waitrequest = 0;
    end else begin
      if (pend) chk("one_outstanding", 64'(fif.flash_read), 64'(0));
      if (stalled) begin
        chk("stall_read_held", 64'(fif.flash_read), 64'(1));
        chk("stall_addr_held", 64'(fif.flash_address), 64'(stall_addr));
      end
      if (pend) begin
        if (cnt <= 1) begin
          fif.flash_readdatavalid = 1;
          fif.flash_readdata = use_ovr ? ovr_data : mem(pend_addr);
          pend = 0;
          rd_done++;
        end else cnt--;
      end
      stalled = 0;
      wr = 0;
      if (fif.flash_read) begin
        if (!in_req) begin
          in_req = 1;
          hold_left = wr_hold_cfg;
          stall_cur = 0;
        end
        if (hold_left > 0) begin
          wr = 1;
          hold_left--;
          stall_cur++;
        end else wr = ($urandom_range(99) < 32'(wr_pct));
        if (wr) begin
          stalled = 1;
          stall_addr = fif.flash_address;
        end else begin
          pend = 1;
          cnt = rand_lat ? int'($urandom_range(4, 1)) : lat_cfg;
          pend_addr = fif.flash_address;
          acc_addr = fif.flash_address;
          in_req = 0;
          stall_last = stall_cur;
          if (mon_en)
            chk("rd_addr", 64'(fif.flash_address), 64'(model_addr));
        end
      end
      fif.flash_waitrequest = wr;
    end
  endtask

  task automatic monitor_step();
    if (!rst) begin
      prev_te = 0;
      pair_cnt = 0;
    end else begin
      if (sample_valid) begin
        sv_total++;
        chk("valid_after_tick", 64'(prev_te), 64'(1));
        chk("pair_order", 64'(pair_cnt < 2), 64'(1));
        pair_cnt++;
        if (mon_en) begin
          chk("rand_sample", 64'(sample_out),
              64'(half(mem(model_addr), forward, model_half)));
          model_half++;
          if (model_half == 2) begin
            model_half = 0;
            model_addr = forward ? model_addr + 1'b1 : model_addr - 1'b1;
          end
        end
      end
      if (addr_change) begin
        ac_total++;
        chk("addr_change_after_pair", 64'(pair_cnt), 64'(2));
        pair_cnt = 0;
        address = forward ? address + 1'b1 : address - 1'b1;
      end
      prev_te = sample_tick && enable;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    responder_step();
    monitor_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 0;
    enable = 0;
    sample_tick = 0;
    cyc();
    cyc();
    rst = 1;
  endtask

  task automatic wait_rd(int n);
    int k = 0;
    while (rd_done < n && k < 300) begin
      cyc();
      k++;
    end
    chk("read_timeout", 64'(rd_done >= n), 64'(1));
  endtask

  task automatic do_tick(string nm, logic [15:0] exp);
    sample_tick = 1;
    cyc();
    sample_tick = 0;
    chk({nm, "_valid"}, 64'(sample_valid), 64'(1));
    chk({nm, "_data"}, 64'(sample_out), 64'(exp));
    cyc();
    chk({nm, "_pulse"}, 64'(sample_valid), 64'(0));
    chk({nm, "_held"}, 64'(sample_out), 64'(exp));
  endtask

  task automatic run_word(logic [AW-1:0] a, bit fwd, logic [31:0] d,
                          logic [15:0] e0, logic [15:0] e1, int hold);
    int n;
    int a0;
    forward = fwd;
    address = a;
    ovr_data = d;
    use_ovr = 1;
    wr_hold_cfg = hold;
    n = rd_done + 1;
    a0 = ac_total;
    enable = 1;
    wait_rd(n);
    wr_hold_cfg = 0;
    chk("acc_addr", 64'(acc_addr), 64'(a));
    chk("flash_address_latched", 64'(fif.flash_address), 64'(a));
    chk("stall_cycles", 64'(stall_last), 64'(hold));
    cyc();
    cyc();
    do_tick("first", e0);
    cyc();
    do_tick("second", e1);
    enable = 0;
    repeat (4) cyc();
    chk("one_addr_change", 64'(ac_total - a0), 64'(1));
    chk("idle_no_read", 64'(fif.flash_read), 64'(0));
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    bit            fwd;
    logic [31:0]   data;
    logic [15:0]   e0;
    logic [15:0]   e1;
    int            hold;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int n, a0, s0, k;
    tbl[0] = '{23'h000010, 1'b1, 32'hBEEF1234, 16'h1234, 16'hBEEF, 0};
    tbl[1] = '{23'h000010, 1'b0, 32'hBEEF1234, 16'hBEEF, 16'h1234, 0};
    tbl[2] = '{23'h000020, 1'b1, 32'hCAFE0001, 16'h0001, 16'hCAFE, 5};
    tbl[3] = '{23'h7FFFFF, 1'b0, 32'h0000FFFF, 16'h0000, 16'hFFFF, 2};
    tbl[4] = '{23'h000000, 1'b1, 32'h5A5AA5A5, 16'hA5A5, 16'h5A5A, 0};

    do_reset();
    chk("rst_flash_read", 64'(fif.flash_read), 64'(0));
    chk("rst_flash_address", 64'(fif.flash_address), 64'(0));
    chk("rst_addr_change", 64'(addr_change), 64'(0));
    chk("rst_sample_out", 64'(sample_out), 64'(0));
    chk("rst_sample_valid", 64'(sample_valid), 64'(0));
`ifdef SAMPLE_UNDERRUN_EN
    chk("rst_underrun", 64'(underrun_count), 64'(0));
`endif

    lat_cfg = 2;
    for (int i = 0; i < 5; i++)
      run_word(tbl[i].addr, tbl[i].fwd, tbl[i].data,
               tbl[i].e0, tbl[i].e1, tbl[i].hold);

    // Pause after the first half; resume must give the second half.
    forward = 1;
    address = 23'h000010;
    ovr_data = 32'hBEEF1234;
    n = rd_done + 1;
    a0 = ac_total;
    enable = 1;
    wait_rd(n);
    cyc();
    cyc();
    do_tick("pause_first", 16'h1234);
    enable = 0;
    s0 = sv_total;
    for (int i = 0; i < 20; i++) begin
      sample_tick = (i % 7 == 3);
      cyc();
    end
    sample_tick = 0;
    chk("pause_no_valid", 64'(sv_total - s0), 64'(0));
    chk("pause_no_addr_change", 64'(ac_total - a0), 64'(0));
    enable = 1;
    cyc();
    do_tick("resume_second", 16'hBEEF);
    enable = 0;
    repeat (4) cyc();
    chk("resume_addr_change", 64'(ac_total - a0), 64'(1));

    // Asynchronous reset while waiting for read data.
    lat_cfg = 10;
    forward = 1;
    address = 23'h000033;
    n = rd_done;
    enable = 1;
    k = 0;
    while (!pend && k < 50) begin
      cyc();
      k++;
    end
    chk("wait_data_reached", 64'(pend), 64'(1));
    cyc();
    #2 rst = 0;
    #1;
    chk("arst_flash_read", 64'(fif.flash_read), 64'(0));
    chk("arst_flash_address", 64'(fif.flash_address), 64'(0));
    chk("arst_sample_out", 64'(sample_out), 64'(0));
    chk("arst_sample_valid", 64'(sample_valid), 64'(0));
    chk("arst_addr_change", 64'(addr_change), 64'(0));
    enable = 0;
    cyc();
    cyc();
    chk("arst_read_abandoned", 64'(rd_done), 64'(n));
    rst = 1;
    lat_cfg = 2;
    run_word(23'h000055, 1'b1, 32'h0BADF00D, 16'hF00D, 16'h0BAD, 0);

    // Randomized playback in both directions.
    for (int ph = 0; ph < 2; ph++) begin
      forward = (ph == 0);
      use_ovr = 0;
      rand_lat = 1;
      wr_pct = 30;
      do_reset();
      address = AW'($urandom);
      model_addr = address;
      model_half = 0;
      mon_en = 1;
      s0 = sv_total;
      for (int i = 0; i < 2500; i++) begin
        enable = ($urandom_range(9) != 0);
        sample_tick = ($urandom_range(3) == 0);
        cyc();
      end
      mon_en = 0;
      enable = 0;
      sample_tick = 0;
      repeat (30) cyc();
      chk("rand_progress", 64'(sv_total - s0 > 100), 64'(1));
    end
    rand_lat = 0;
    wr_pct = 0;

`ifdef SAMPLE_UNDERRUN_EN
    do_reset();
    use_ovr = 1;
    ovr_data = 32'h11112222;
    address = 23'h000100;
    wr_hold_cfg = 4;
    lat_cfg = 3;
    enable = 1;
    k = 0;
    while (!fif.flash_read && k < 20) begin
      cyc();
      k++;
    end
    sample_tick = 1;
    cyc();
    cyc();
    sample_tick = 0;
    k = 0;
    while (!(pend && cnt == 1) && k < 50) begin
      cyc();
      k++;
    end
    sample_tick = 1;
    cyc();
    sample_tick = 0;
    wr_hold_cfg = 0;
    chk("underrun_three", 64'(underrun_count), 64'(3));
    chk("underrun_no_valid", 64'(sample_valid), 64'(0));

    lat_cfg = 70000;
    rst = 0;
    enable = 1;
    sample_tick = 1;
    cyc();
    rst = 1;
    repeat (65534) cyc();
    chk("underrun_near_max", 64'(underrun_count), 64'(16'hFFFE));
    cyc();
    chk("underrun_max", 64'(underrun_count), 64'(16'hFFFF));
    repeat (5) cyc();
    chk("underrun_saturate", 64'(underrun_count), 64'(16'hFFFF));
    sample_tick = 0;
    enable = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
